// File: rtl/pipe_skid_16b.sv
// pipe_skid_16b: valid/ready pipeline stage with a one-entry skid buffer.
// in_ready is taken from a flop, so a downstream stall never reaches the
// upstream handshake through combinational logic. A synchronous flush
// squashes every held word for branch recovery.
module pipe_skid_16b #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic [1:0]       occupancy
);

  // The state encoding is {out_valid, skid_valid}. The pair 2'b01 is never
  // entered; if it ever appears, the stage recovers to EMPTY.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             in_ready_q, in_ready_d;
  logic             accept, drain;
  logic             skid_valid;

  assign skid_valid = state_q[0];
  assign out_valid  = state_q[1];
  assign out_data   = out_data_q;
  assign in_ready   = in_ready_q;
  assign occupancy  = {1'b0, out_valid} + {1'b0, skid_valid};

  assign accept = in_valid & in_ready_q;
  assign drain  = out_valid & out_ready;

  // Next state and data-register loads. Flush overrides only the valid state.
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    skid_data_d = skid_data_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          out_data_d = in_data;
          state_d    = ONE;
        end
      end
      ONE: begin
        if (accept && drain) begin
          out_data_d = in_data;
        end else if (drain) begin
          state_d = EMPTY;
        end else if (accept) begin
          skid_data_d = in_data;
          state_d     = FULL;
        end
      end
      FULL: begin
        // in_ready is low here, so nothing new can arrive in this cycle.
        if (drain) begin
          out_data_d = skid_data_q;
          state_d    = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
    // Ready exactly when the skid slot will be free after this edge.
    in_ready_d = ~state_d[0];
  end

  // State, data and ready registers, with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EMPTY;
      out_data_q  <= '0;
      skid_data_q <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_16b.sv
// Directed-vector and random checking bench for pipe_skid_16b.
module tb_pipe_skid_16b;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_skid_16b #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .flush(flush), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        iv;
    logic [15:0] id;
    logic        ordy;
    logic        fl;
    logic        eov;
    logic [15:0] eod;
    logic        eir;
    logic [1:0]  eocc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive inputs for one cycle, then land 1 time unit past the edge.
  task automatic cyc(input logic iv, input logic [15:0] id, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic eov, input logic [15:0] eod,
                          input logic eir, input logic [1:0] eocc);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, eov});
    if (eov) chk({tag, ".out_data"}, {16'd0, out_data}, {16'd0, eod});
    chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, eir});
    chk({tag, ".occupancy"}, {30'd0, occupancy}, {30'd0, eocc});
  endtask

  initial begin
    logic [15:0] q[$];
    logic        acc, drn, pov, pordy, pfl;
    logic [15:0] pod;

    // Reset held with a word offered upstream: nothing may be captured.
    in_valid = 1'b1; in_data = 16'hBEEF; out_ready = 1'b0;
    #1 rst = 1'b0;
    #1 chk_outs("rst_async", 1'b0, 16'h0, 1'b1, 2'd0);
    chk("rst_async.out_data", {16'd0, out_data}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_outs("rst_hold", 1'b0, 16'h0, 1'b1, 2'd0);
    end
    rst = 1'b1;
    cyc(1'b1, 16'hBEEF, 1'b0, 1'b0);
    chk_outs("rst_release", 1'b1, 16'hBEEF, 1'b1, 2'd1);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    chk_outs("rst_drain", 1'b0, 16'h0, 1'b1, 2'd0);

    // Streaming 0001..0008 at one word per cycle.
    for (int i = 1; i <= 8; i++)
      vecs.push_back('{1'b1, 16'(i), 1'b1, 1'b0, 1'b1, 16'(i), 1'b1, 2'd1});
    vecs.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 2'd0});
    // Stall: A000 to main, A001 to skid, A002 held back, then release.
    vecs.push_back('{1'b1, 16'hA000, 1'b0, 1'b0, 1'b1, 16'hA000, 1'b1, 2'd1});
    vecs.push_back('{1'b1, 16'hA001, 1'b0, 1'b0, 1'b1, 16'hA000, 1'b0, 2'd2});
    vecs.push_back('{1'b1, 16'hA002, 1'b0, 1'b0, 1'b1, 16'hA000, 1'b0, 2'd2});
    vecs.push_back('{1'b1, 16'hA002, 1'b1, 1'b0, 1'b1, 16'hA001, 1'b1, 2'd1});
    vecs.push_back('{1'b1, 16'hA002, 1'b1, 1'b0, 1'b1, 16'hA002, 1'b1, 2'd1});
    vecs.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 2'd0});
    // Flush in FULL with DEAD offered.
    vecs.push_back('{1'b1, 16'hB000, 1'b0, 1'b0, 1'b1, 16'hB000, 1'b1, 2'd1});
    vecs.push_back('{1'b1, 16'hB001, 1'b0, 1'b0, 1'b1, 16'hB000, 1'b0, 2'd2});
    vecs.push_back('{1'b1, 16'hDEAD, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 2'd0});
    // Flush in ONE beats a simultaneous accept of DEAD.
    vecs.push_back('{1'b1, 16'hC000, 1'b0, 1'b0, 1'b1, 16'hC000, 1'b1, 2'd1});
    vecs.push_back('{1'b1, 16'hDEAD, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 2'd0});
    vecs.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 2'd0});
    vecs.push_back('{1'b1, 16'hC001, 1'b1, 1'b0, 1'b1, 16'hC001, 1'b1, 2'd1});
    vecs.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 2'd0});

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].iv, vecs[i].id, vecs[i].ordy, vecs[i].fl);
      chk_outs($sformatf("vec%0d", i), vecs[i].eov, vecs[i].eod, vecs[i].eir, vecs[i].eocc);
      if (out_valid && out_data == 16'hDEAD) chk("dead_leak", 32'd1, 32'd0);
    end

    // Asynchronous reset mid-cycle while FULL, then one word alone.
    cyc(1'b1, 16'hE000, 1'b0, 1'b0);
    cyc(1'b1, 16'hE001, 1'b0, 1'b0);
    chk_outs("full_pre_rst", 1'b1, 16'hE000, 1'b0, 2'd2);
    in_valid = 1'b0;
    #3 rst = 1'b0;
    #1 chk_outs("rst_mid", 1'b0, 16'h0, 1'b1, 2'd0);
    chk("rst_mid.out_data", {16'd0, out_data}, 32'd0);
    #1 rst = 1'b1;
    cyc(1'b1, 16'h1234, 1'b1, 1'b0);
    chk_outs("post_rst_1234", 1'b1, 16'h1234, 1'b1, 2'd1);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    chk_outs("post_rst_alone", 1'b0, 16'h0, 1'b1, 2'd0);

    // Random traffic against a queue model; the stage is empty here.
    q = {};
    for (int c = 0; c < 10000; c++) begin
      logic        iv, ordy, fl;
      logic [15:0] d;
      iv   = 1'($urandom_range(0, 1));
      ordy = 1'($urandom_range(0, 1));
      fl   = ($urandom_range(0, 49) == 0);
      d    = 16'($urandom);
      acc  = iv && (q.size() < 2);
      drn  = ordy && (q.size() > 0);
      pov = out_valid; pod = out_data; pordy = ordy; pfl = fl;
      cyc(iv, d, ordy, fl);
      if (drn) void'(q.pop_front());
      if (fl) q = {};
      else if (acc) q.push_back(d);
      chk("rnd.out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
      if (q.size() > 0) chk("rnd.out_data", {16'd0, out_data}, {16'd0, q[0]});
      chk("rnd.in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
      chk("rnd.occupancy", {30'd0, occupancy}, 32'(q.size()));
      chk("rnd.legal_state", {31'd0, (!out_valid && occupancy != 2'd0) || occupancy > 2'd2}, 32'd0);
      if (pov && !pordy && !pfl)
        chk("rnd.stall_stable", {15'd0, out_valid, out_data}, {15'd0, 1'b1, pod});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_skid_16b.md
# pipe_skid_16b

Stall-capable pipeline stage placed between processor pipeline stages such as IF/ID and ID/EX. It accepts 16-bit words from the upstream stage on a valid/ready handshake and presents them downstream on a matching handshake. A one-entry skid buffer keeps `in_ready` a pure register output, so downstream stalls never form a combinational path back upstream. Sustained throughput is one word per cycle; the block also supports a synchronous flush for branch squash.

## Interface
- `WIDTH`, default 16: data width in bits.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous reset, active-low (`rst`=0 resets).
- `in_valid`  in  1  upstream word present on `in_data`.
- `in_data`  in  WIDTH  upstream word.
- `in_ready`  out  1  block can accept a word this cycle; registered.
- `out_valid`  out  1  `out_data` holds a valid word.
- `out_data`  out  WIDTH  word presented downstream; registered.
- `out_ready`  in  1  downstream consumes `out_data` this cycle.
- `flush`  in  1  synchronous squash of all held words.
- `occupancy`  out  2  number of words held: 0, 1 or 2.

## Operation
- Storage:
  - Main register: `out_data` / `out_valid`.
  - Skid register: `skid_data` / `skid_valid`.
- `in_ready` = !`skid_valid`, driven from a flop.
- Handshake definitions:
  - Accept = `in_valid` & `in_ready`.
  - Drain = `out_valid` & `out_ready`.
- Data is never reordered. Output order always equals accept order.
- Next-state rules, evaluated at each edge when `flush`=0:
  - Main empty, or main draining with skid empty: an accepted word loads main. `out_valid` becomes the accept value.
  - Main draining with skid full: skid moves to main and the skid empties. No accept is possible, because `in_ready`=0.
  - Main full, not draining, skid empty, accept: the word loads skid and `skid_valid` is set.
  - Main full, not draining, skid full: hold all state.
- States, encoded as (`out_valid`, `skid_valid`):
  - EMPTY (0,0).
  - ONE (1,0).
  - FULL (1,1).
  - (0,1) is illegal and never reachable.
- Transitions:
  - EMPTY→ONE on accept.
  - ONE→ONE on accept and drain together, or on neither.
  - ONE→EMPTY on drain without accept.
  - ONE→FULL on accept without drain.
  - FULL→ONE on drain.
  - FULL→FULL otherwise.
- `occupancy` = `out_valid` + `skid_valid`.
- Flush:
  - `flush`=1 at an edge clears `out_valid` and `skid_valid` and sets `in_ready`=1. State goes to EMPTY.
  - Flush has priority over a simultaneous accept; that word is discarded.
  - A drain in the flush cycle still counts as consumed downstream.
- Data registers:
  - Load only when their rules above select them; they are not cleared by flush.
  - `out_data` is don't-care while `out_valid`=0.
  - Verification checks data only when valid.

## Timing
- Reset (`rst`=0, asynchronous, immediate):
  - `out_valid`=0, `skid_valid`=0, `out_data`=0, `occupancy`=0.
  - `in_ready`=1.
- Reset mid-operation drops all held words. The first edge after `rst` returns high behaves as from EMPTY.
- Latency: a word accepted at edge N appears on `out_data` with `out_valid`=1 immediately after edge N, when main was free.
- Throughput: with `out_ready` held at 1, one word per cycle passes indefinitely. `in_ready` stays 1.
- Backpressure:
  - `out_ready` dropping at edge N lets at most one more word be accepted, into skid.
  - `in_ready` falls after that edge.
  - `in_ready` rises the cycle after the first subsequent drain.
- `out_valid` and `out_data` must stay stable while `out_valid`=1 and `out_ready`=0.
- No combinational path from `out_ready` or `flush` to any output.

## Test plan
- Reset with `in_valid`=1 and `in_data`=16'hBEEF held during `rst`=0: `out_valid`=0, `in_ready`=1, `occupancy`=0 throughout. The word is first accepted at the first edge after release.
- Streaming: feed 16'h0001…16'h0008 back-to-back with `out_ready`=1. Outputs are 0001…0008 on consecutive cycles at 1-cycle latency, and `in_ready` never drops.
- Stall:
  - Send 16'hA000, A001, A002 with `out_ready`=0. A000 lands in main and A001 in skid; `in_ready`=0 and `occupancy`=2. A002 is held upstream.
  - Raise `out_ready`. The block outputs A000, A001, A002 in order, and `in_ready` returns to 1 one cycle after the first drain.
- Flush in FULL with a simultaneous `in_valid` of 16'hDEAD:
  - Next cycle: `occupancy`=0, `out_valid`=0, `in_ready`=1.
  - DEAD never appears on the output.
- Async reset asserted mid-cycle in FULL: all outputs go to reset values before the next edge. A following word 16'h1234 emerges alone.
- Random `in_valid`/`out_ready` over 10,000 cycles against a queue model:
  - Order and data are preserved.
  - `occupancy` never exceeds 2.
  - The state (0,1) never occurs.
  - Output is stable while stalled.
